pb_reduction_offload_arbiter: RTL and testbench
===============================================

Name: pb_reduction_offload_arbiter

Overview:
- Shares one reduction ALU between the narrow and wide reduction offload ports of a floo_nw_router in a Picobello tile.
- Requests from both ports are arbitrated round-robin onto the single ALU request channel.
- An in-order owner-tag FIFO returns each ALU result to the port that issued the operation.
- Sits between the router's offload_{narrow,wide}_* ports and the tile's shared reduction unit.

Parameters:
- OpWidth, 4, width of the reduction opcode.
- NarrowWidth, 64, narrow operand/result width.
- WideWidth, 512, ALU operand/result width; must be >= NarrowWidth.
- MaxOutstanding, 4, tag FIFO depth (maximum ALU ops in flight); power of two, >= 1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- n_req_op_i / n_req_operand1_i / n_req_operand2_i  in  OpWidth/NarrowWidth/NarrowWidth  narrow request payload.
- n_req_valid_i  in  1; n_req_ready_o  out  1  narrow request handshake.
- n_resp_result_o  out  NarrowWidth; n_resp_valid_o  out  1; n_resp_ready_i  in  1  narrow response.
- w_req_op_i / w_req_operand1_i / w_req_operand2_i  in  OpWidth/WideWidth/WideWidth  wide request payload.
- w_req_valid_i  in  1; w_req_ready_o  out  1  wide request handshake.
- w_resp_result_o  out  WideWidth; w_resp_valid_o  out  1; w_resp_ready_i  in  1  wide response.
- alu_req_op_o / alu_req_operand1_o / alu_req_operand2_o  out  OpWidth/WideWidth/WideWidth  ALU request payload.
- alu_req_valid_o  out  1; alu_req_ready_i  in  1  ALU request handshake.
- alu_resp_result_i  in  WideWidth; alu_resp_valid_i  in  1; alu_resp_ready_o  out  1  ALU response.
- outstanding_o  out  $clog2(MaxOutstanding)+1  ops in flight.
- resp_err_o  out  1  sticky: ALU response arrived with the FIFO empty.

Behaviour:
- Reset: all valid/ready outputs 0, outstanding_o=0, resp_err_o=0, priority pointer = narrow, lock cleared, FIFO empty.
- Request path is zero-latency: no payload registers. A request handshakes in the same cycle as the ALU handshake (req ready_o = grant & alu_req_ready_i).
- Arbitration:
  - Eligible only when the FIFO is not full; a pop in the same cycle does not free a slot.
  - One requester valid: it is granted.
  - Both valid: the port pointed to by the priority register is granted.
  - After each ALU request handshake, the priority register points to the other port.
- Lock: while alu_req_valid_o=1 and alu_req_ready_i=0, the grant is frozen and the mux selection does not change, even if the other port asserts valid. This guarantees payload stability to the ALU. The lock clears on handshake.
- Narrow payload: operands are zero-extended to WideWidth; the opcode passes through unchanged.
- Tag FIFO:
  - On an ALU request handshake, push the owner bit (0=narrow, 1=wide).
  - On an ALU response handshake, pop.
  - Push and pop in the same cycle are both performed; the count is unchanged.
  - outstanding_o equals the FIFO count.
- Response routing (combinational from the FIFO head):
  - The owner's resp_valid_o = alu_resp_valid_i; the other port's resp_valid_o = 0.
  - alu_resp_ready_o = the owner's resp_ready_i.
  - Narrow result = alu_resp_result_i[NarrowWidth-1:0]. Each resp_result_o is driven from the ALU result regardless of valid.
- FIFO empty: alu_resp_ready_o=0 and both resp_valid_o=0. If alu_resp_valid_i=1 while empty, set resp_err_o; it stays set until reset.
- Pointers wrap modulo MaxOutstanding.
- Reset mid-operation clears everything immediately (asynchronous); in-flight ALU ops are abandoned. The ALU is reset together with the arbiter.

Test Plan:
- Narrow only, ALU always ready: 3 ops (operand1=0x1,0x2,0x3) -> alu_req_operand1_o=zero-extended values in order; 3 responses go to the narrow port; outstanding_o goes 0→1 per push and returns to 0; wide port never sees valid.
- Both ports valid every cycle, ALU always ready, responses immediate -> grants alternate N,W,N,W starting with N after reset; each response goes to its issuer (result 0xA5 in low bits reaches n_resp_result_o = 0xA5).
- Lock: narrow valid, alu_req_ready_i=0 for 5 cycles, wide asserts valid in cycle 2 -> ALU payload stays narrow for all 5 cycles; narrow handshakes in cycle 6; wide is granted next.
- Full FIFO: MaxOutstanding=4, hold ALU responses, issue 5 requests -> 4 accepted, outstanding_o=4, the 5th request's ready stays 0. Release one response with a simultaneous request -> no push that cycle; push happens the next cycle.
- Response backpressure: owner=wide, w_resp_ready_i=0 for 3 cycles while alu_resp_valid_i=1 -> alu_resp_ready_o=0 for those cycles; FIFO is not popped; n_resp_valid_o=0 throughout.
- Spurious response with the FIFO empty -> resp_err_o=1 the next cycle and sticky; assert rst_ni low mid-traffic -> all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/pb_reduction_offload_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pb_reduction_offload_arbiter: round-robin share of one reduction ALU between
// the narrow and wide router offload ports, with in-order result return.
// Revision: 1.0
// ----------------------------------------------------------------------------
module pb_reduction_offload_arbiter #(
  parameter int unsigned OpWidth        = 4,
  parameter int unsigned NarrowWidth    = 64,
  parameter int unsigned WideWidth      = 512,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [OpWidth-1:0]                n_req_op_i,
  input  logic [NarrowWidth-1:0]            n_req_operand1_i,
  input  logic [NarrowWidth-1:0]            n_req_operand2_i,
  input  logic                              n_req_valid_i,
  output logic                              n_req_ready_o,
  output logic [NarrowWidth-1:0]            n_resp_result_o,
  output logic                              n_resp_valid_o,
  input  logic                              n_resp_ready_i,
  input  logic [OpWidth-1:0]                w_req_op_i,
  input  logic [WideWidth-1:0]              w_req_operand1_i,
  input  logic [WideWidth-1:0]              w_req_operand2_i,
  input  logic                              w_req_valid_i,
  output logic                              w_req_ready_o,
  output logic [WideWidth-1:0]              w_resp_result_o,
  output logic                              w_resp_valid_o,
  input  logic                              w_resp_ready_i,
  output logic [OpWidth-1:0]                alu_req_op_o,
  output logic [WideWidth-1:0]              alu_req_operand1_o,
  output logic [WideWidth-1:0]              alu_req_operand2_o,
  output logic                              alu_req_valid_o,
  input  logic                              alu_req_ready_i,
  input  logic [WideWidth-1:0]              alu_resp_result_i,
  input  logic                              alu_resp_valid_i,
  output logic                              alu_resp_ready_o,
  output logic [$clog2(MaxOutstanding):0]   outstanding_o,
  output logic                              resp_err_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding) + 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic [MaxOutstanding-1:0] tags;
  logic [PtrW-1:0]           wr_ptr;
  logic [PtrW-1:0]           rd_ptr;
  logic [CntW-1:0]           count;
  logic                      prio;
  logic                      locked;
  logic                      lock_owner;
  logic                      sel;
  logic                      sel_valid;
  logic                      full;
  logic                      empty;
  logic                      head;
  logic                      req_hs;
  logic                      resp_hs;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // A stalled ALU request keeps its owner so the payload cannot switch under it.
  always_comb begin
    sel = 1'b0;
    if (locked) begin
      sel = lock_owner;
    end else if (n_req_valid_i && w_req_valid_i) begin
      sel = prio;
    end else begin
      sel = w_req_valid_i;
    end
  end

  assign full      = (count == CntW'(MaxOutstanding));
  assign empty     = (count == '0);
  assign sel_valid = sel ? w_req_valid_i : n_req_valid_i;

  assign alu_req_valid_o    = rst_ni & ~full & sel_valid;
  assign req_hs             = alu_req_valid_o & alu_req_ready_i;
  assign n_req_ready_o      = req_hs & ~sel;
  assign w_req_ready_o      = req_hs & sel;
  assign alu_req_op_o       = sel ? w_req_op_i : n_req_op_i;
  assign alu_req_operand1_o = sel ? w_req_operand1_i : WideWidth'(n_req_operand1_i);
  assign alu_req_operand2_o = sel ? w_req_operand2_i : WideWidth'(n_req_operand2_i);

  assign head             = tags[rd_ptr];
  assign alu_resp_ready_o = ~empty & (head ? w_resp_ready_i : n_resp_ready_i);
  assign n_resp_valid_o   = ~empty & ~head & alu_resp_valid_i;
  assign w_resp_valid_o   = ~empty & head & alu_resp_valid_i;
  assign resp_hs          = alu_resp_valid_i & alu_resp_ready_o;
  assign n_resp_result_o  = alu_resp_result_i[NarrowWidth-1:0];
  assign w_resp_result_o  = alu_resp_result_i;
  assign outstanding_o    = count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tags       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      prio       <= 1'b0;
      locked     <= 1'b0;
      lock_owner <= 1'b0;
      resp_err_o <= 1'b0;
    end else begin
      locked     <= alu_req_valid_o & ~alu_req_ready_i;
      lock_owner <= sel;
      if (req_hs) begin
        tags[wr_ptr] <= sel;
        wr_ptr       <= ptr_inc(wr_ptr);
        prio         <= ~sel;
      end
      if (resp_hs) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({req_hs, resp_hs})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
      if (alu_resp_valid_i && empty) begin
        resp_err_o <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pb_reduction_offload_arbiter.sv
`default_nettype none
// tb_pb_reduction_offload_arbiter: directed stimulus with an in-bench queue model
// checked every cycle, plus literal expectations per scenario.
module tb_pb_reduction_offload_arbiter;
  localparam int OW = 4;
  localparam int NW = 64;
  localparam int WW = 512;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [OW-1:0] n_req_op, w_req_op, alu_req_op;
  logic [NW-1:0] n_req_operand1, n_req_operand2, n_resp_result;
  logic [WW-1:0] w_req_operand1, w_req_operand2, w_resp_result;
  logic [WW-1:0] alu_req_operand1, alu_req_operand2, alu_resp_result;
  logic n_req_valid, n_req_ready, n_resp_valid, n_resp_ready;
  logic w_req_valid, w_req_ready, w_resp_valid, w_resp_ready;
  logic alu_req_valid, alu_req_ready, alu_resp_valid, alu_resp_ready;
  logic [$clog2(MO):0] outstanding;
  logic resp_err;

  int checks = 0;
  int failures = 0;

  bit owners[$];
  bit m_prio = 1'b0;
  bit m_locked = 1'b0;
  bit m_lock_owner = 1'b0;
  bit m_err = 1'b0;
  bit grant_seq [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  pb_reduction_offload_arbiter #(
    .OpWidth(OW), .NarrowWidth(NW), .WideWidth(WW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .n_req_op_i(n_req_op), .n_req_operand1_i(n_req_operand1), .n_req_operand2_i(n_req_operand2),
    .n_req_valid_i(n_req_valid), .n_req_ready_o(n_req_ready),
    .n_resp_result_o(n_resp_result), .n_resp_valid_o(n_resp_valid), .n_resp_ready_i(n_resp_ready),
    .w_req_op_i(w_req_op), .w_req_operand1_i(w_req_operand1), .w_req_operand2_i(w_req_operand2),
    .w_req_valid_i(w_req_valid), .w_req_ready_o(w_req_ready),
    .w_resp_result_o(w_resp_result), .w_resp_valid_o(w_resp_valid), .w_resp_ready_i(w_resp_ready),
    .alu_req_op_o(alu_req_op), .alu_req_operand1_o(alu_req_operand1), .alu_req_operand2_o(alu_req_operand2),
    .alu_req_valid_o(alu_req_valid), .alu_req_ready_i(alu_req_ready),
    .alu_resp_result_i(alu_resp_result), .alu_resp_valid_i(alu_resp_valid), .alu_resp_ready_o(alu_resp_ready),
    .outstanding_o(outstanding), .resp_err_o(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: FIFO of issuers, round-robin pointer, stalled-request owner, sticky error.
  always @(negedge clk) begin : compare
    bit full, own, ev, hs, rhs, empty, head;
    if (!rst_ni) begin
      owners.delete();
      m_prio = 1'b0;
      m_locked = 1'b0;
      m_err = 1'b0;
      chk("rst_alu_req_valid", alu_req_valid, 0);
      chk("rst_n_req_ready", n_req_ready, 0);
      chk("rst_w_req_ready", w_req_ready, 0);
      chk("rst_alu_resp_ready", alu_resp_ready, 0);
      chk("rst_n_resp_valid", n_resp_valid, 0);
      chk("rst_w_resp_valid", w_resp_valid, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_resp_err", resp_err, 0);
    end else begin
      full = owners.size() >= MO;
      if (m_locked) own = m_lock_owner;
      else if (n_req_valid && w_req_valid) own = m_prio;
      else own = w_req_valid;
      ev = !full && (own ? w_req_valid : n_req_valid);
      hs = ev && alu_req_ready;
      chk("m_alu_req_valid", alu_req_valid, ev);
      chk("m_n_req_ready", n_req_ready, hs && !own);
      chk("m_w_req_ready", w_req_ready, hs && own);
      if (ev) begin
        chk("m_alu_op", alu_req_op, own ? w_req_op : n_req_op);
        chk("m_alu_operand1", alu_req_operand1, own ? w_req_operand1 : WW'(n_req_operand1));
        chk("m_alu_operand2", alu_req_operand2, own ? w_req_operand2 : WW'(n_req_operand2));
      end
      empty = owners.size() == 0;
      head = empty ? 1'b0 : owners[0];
      rhs = !empty && alu_resp_valid && (head ? w_resp_ready : n_resp_ready);
      chk("m_n_resp_valid", n_resp_valid, !empty && !head && alu_resp_valid);
      chk("m_w_resp_valid", w_resp_valid, !empty && head && alu_resp_valid);
      chk("m_alu_resp_ready", alu_resp_ready, !empty && (head ? w_resp_ready : n_resp_ready));
      chk("m_n_resp_result", n_resp_result, alu_resp_result[NW-1:0]);
      chk("m_w_resp_result", w_resp_result, alu_resp_result);
      chk("m_outstanding", outstanding, owners.size());
      chk("m_resp_err", resp_err, m_err);
      if (alu_resp_valid && empty) m_err = 1'b1;
      if (rhs) void'(owners.pop_front());
      if (hs) begin
        owners.push_back(own);
        m_prio = !own;
      end
      m_locked = ev && !alu_req_ready;
      m_lock_owner = own;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    n_req_valid = 0; n_req_op = '0; n_req_operand1 = '0; n_req_operand2 = '0;
    w_req_valid = 0; w_req_op = '0; w_req_operand1 = '0; w_req_operand2 = '0;
    alu_resp_valid = 0; alu_resp_result = '0;
  endtask

  task automatic do_reset();
    cyc(); idle(); rst_ni = 0;
    cyc(); cyc(); rst_ni = 1;
  endtask

  initial begin
    idle();
    alu_req_ready = 1; n_resp_ready = 1; w_resp_ready = 1;
    repeat (3) cyc();
    #1;
    chk("reset_outstanding", outstanding, 0);
    chk("reset_alu_req_valid", alu_req_valid, 0);
    chk("reset_resp_err", resp_err, 0);
    rst_ni = 1;

    // Narrow-only traffic
    for (int i = 1; i <= 3; i++) begin
      cyc(); n_req_valid = 1; n_req_op = OW'(i); n_req_operand1 = NW'(i); n_req_operand2 = NW'(i + 16);
      #1;
      chk("t1_operand1_zext", alu_req_operand1, WW'(i));
      chk("t1_n_ready", n_req_ready, 1);
      chk("t1_outstanding_pre", outstanding, i - 1);
    end
    cyc(); n_req_valid = 0; #1;
    chk("t1_outstanding_3", outstanding, 3);
    for (int i = 1; i <= 3; i++) begin
      cyc(); alu_resp_valid = 1; alu_resp_result = WW'(i); #1;
      chk("t1_n_resp_valid", n_resp_valid, 1);
      chk("t1_w_resp_valid", w_resp_valid, 0);
      chk("t1_n_resp_result", n_resp_result, i);
    end
    cyc(); idle(); #1;
    chk("t1_outstanding_0", outstanding, 0);

    // Both ports valid every cycle, alternating grants from narrow after reset
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cyc();
      n_req_valid = 1; n_req_operand1 = NW'(16 + k);
      w_req_valid = 1; w_req_operand1 = WW'(32 + k);
      alu_resp_valid = (k > 0); alu_resp_result = WW'(8'hA5);
      #1;
      chk("t2_n_grant", n_req_ready, !grant_seq[k]);
      chk("t2_w_grant", w_req_ready, grant_seq[k]);
      if (k > 0 && !grant_seq[k-1]) begin
        chk("t2_n_resp_valid", n_resp_valid, 1);
        chk("t2_n_resp_result", n_resp_result, 64'hA5);
      end else if (k > 0) begin
        chk("t2_w_resp_valid", w_resp_valid, 1);
      end
    end
    cyc(); n_req_valid = 0; w_req_valid = 0; alu_resp_valid = 1; #1;
    chk("t2_last_w_resp", w_resp_valid, 1);
    cyc(); idle(); #1;
    chk("t2_outstanding_0", outstanding, 0);

    // Lock: point priority at wide first, then stall a narrow request
    cyc(); n_req_valid = 1; n_req_operand1 = 64'h11; #1;
    chk("t3_pre_n_ready", n_req_ready, 1);
    cyc(); n_req_valid = 0; alu_resp_valid = 1; #1;
    chk("t3_pre_n_resp", n_resp_valid, 1);
    for (int c = 1; c <= 5; c++) begin
      cyc(); alu_resp_valid = 0; alu_req_ready = 0;
      n_req_valid = 1; n_req_operand1 = 64'h33;
      w_req_valid = (c >= 2); w_req_operand1 = WW'(8'h44);
      #1;
      chk("t3_lock_operand1", alu_req_operand1, WW'(8'h33));
      chk("t3_lock_valid", alu_req_valid, 1);
      chk("t3_lock_w_ready", w_req_ready, 0);
    end
    cyc(); alu_req_ready = 1; #1;
    chk("t3_n_handshake", n_req_ready, 1);
    chk("t3_w_not_yet", w_req_ready, 0);
    cyc(); n_req_valid = 0; #1;
    chk("t3_w_next", w_req_ready, 1);
    chk("t3_w_operand1", alu_req_operand1, WW'(8'h44));
    cyc(); w_req_valid = 0; alu_resp_valid = 1; #1;
    chk("t3_resp_n", n_resp_valid, 1);
    cyc(); #1;
    chk("t3_resp_w", w_resp_valid, 1);
    cyc(); idle(); #1;
    chk("t3_outstanding_0", outstanding, 0);

    // Full FIFO
    for (int c = 1; c <= 5; c++) begin
      cyc(); n_req_valid = 1; n_req_operand1 = NW'(c); #1;
      chk("t4_n_ready", n_req_ready, c <= 4);
    end
    chk("t4_outstanding_full", outstanding, 4);
    cyc(); alu_resp_valid = 1; #1;
    chk("t4_pop_ready", alu_resp_ready, 1);
    chk("t4_no_push_on_pop", n_req_ready, 0);
    chk("t4_outstanding_4", outstanding, 4);
    cyc(); alu_resp_valid = 0; #1;
    chk("t4_push_after", n_req_ready, 1);
    chk("t4_outstanding_3", outstanding, 3);
    for (int d = 0; d < 4; d++) begin
      cyc(); n_req_valid = 0; alu_resp_valid = 1; #1;
      chk("t4_drain", outstanding, 4 - d);
    end
    cyc(); idle(); #1;
    chk("t4_outstanding_0", outstanding, 0);

    // Wide response backpressure
    cyc(); w_req_valid = 1; w_req_operand1 = WW'(8'h55); #1;
    chk("t5_w_ready", w_req_ready, 1);
    for (int c = 0; c < 3; c++) begin
      cyc(); w_req_valid = 0; alu_resp_valid = 1; alu_resp_result = WW'(8'h77); w_resp_ready = 0; #1;
      chk("t5_alu_resp_ready", alu_resp_ready, 0);
      chk("t5_w_resp_valid", w_resp_valid, 1);
      chk("t5_n_resp_valid", n_resp_valid, 0);
      chk("t5_outstanding", outstanding, 1);
    end
    cyc(); w_resp_ready = 1; #1;
    chk("t5_release", alu_resp_ready, 1);
    chk("t5_w_result", w_resp_result, WW'(8'h77));
    cyc(); idle(); #1;
    chk("t5_outstanding_0", outstanding, 0);

    // Spurious response, then reset in the middle of traffic
    cyc(); alu_resp_valid = 1; #1;
    chk("t6_err_before", resp_err, 0);
    cyc(); alu_resp_valid = 0; #1;
    chk("t6_err_set", resp_err, 1);
    cyc(); #1;
    chk("t6_err_sticky", resp_err, 1);
    cyc(); n_req_valid = 1; w_req_valid = 1;
    cyc(); alu_resp_valid = 1; #1;
    rst_ni = 0; #1;
    chk("t6_async_outstanding", outstanding, 0);
    chk("t6_async_err", resp_err, 0);
    chk("t6_async_alu_req_valid", alu_req_valid, 0);
    chk("t6_async_n_ready", n_req_ready, 0);
    chk("t6_async_w_ready", w_req_ready, 0);
    chk("t6_async_alu_resp_ready", alu_resp_ready, 0);
    chk("t6_async_resp_valids", {n_resp_valid, w_resp_valid}, 0);
    cyc(); cyc(); idle(); rst_ni = 1;
    cyc(); #1;
    chk("t6_post_outstanding", outstanding, 0);
    chk("t6_post_err", resp_err, 0);

    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
